// File: rtl/jtbubl_snd_pkg.sv
// Shared register map, reset values and access decode type for the sound-latch block.
package jtbubl_snd_pkg;

  localparam logic [1:0] ADDR_CMD     = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_NMI_ON  = 2'd1;
  localparam logic [1:0] ADDR_NMI_OFF = 2'd2;
  localparam logic [1:0] ADDR_RST     = 2'd3;

  localparam logic [7:0] RST_LATCH   = 8'h00;
  localparam logic [7:0] RST_DOUT    = 8'hFF;
  localparam logic [7:0] OPEN_BUS    = 8'hFF;
  localparam logic       RST_SND_RST = 1'b1;

  // One decoded bus access, valid only on the first cycle of a strobe.
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [1:0] addr;
  } acc_t;

  function automatic logic [7:0] status_byte(input logic reply_pend, input logic cmd_pend);
    return {6'b0, reply_pend, cmd_pend};
  endfunction

endpackage

// File: rtl/jtbubl_sndcomm_latch.sv
// 8-bit mailbox latch with pending flag; a set in the same cycle as a clear wins.
module jtbubl_sndcomm_latch
  import jtbubl_snd_pkg::*;
(
  input  logic       clk24,
  input  logic       rst_n,
  input  logic       set_i,
  input  logic       clr_i,
  input  logic [7:0] din_i,
  output logic [7:0] data_o,
  output logic       pend_o
);

  logic [7:0] data_q, data_d;
  logic       pend_q, pend_d;

  always_comb begin
    data_d = data_q;
    pend_d = pend_q;
    if (clr_i) pend_d = 1'b0;
    if (set_i) begin
      data_d = din_i;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RST_LATCH;
      pend_q <= 1'b0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign data_o = data_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/jtbubl_sndcomm.sv
// Main/sound CPU mailbox: command latch, optional reply latch (JTBUBL_SNDREPLY_EN),
// NMI enable and sound CPU reset control.
module jtbubl_sndcomm
  import jtbubl_snd_pkg::*;
(
  input  logic       clk24,
  input  logic       rst_n,
  input  logic       main_cs,
  input  logic       main_wr,
  input  logic [1:0] main_addr,
  input  logic [7:0] main_din,
  output logic [7:0] main_dout,
  input  logic       snd_cs,
  input  logic       snd_wr,
  input  logic [1:0] snd_addr,
  input  logic [7:0] snd_din,
  output logic [7:0] snd_dout,
  output logic       snd_nmi_n,
  output logic       snd_rst
);

  logic       main_cs_q, snd_cs_q;
  logic       snd_rst_q, snd_rst_d;
  logic       nmi_en_q, nmi_en_d;
  logic       snd_nmi_n_q, snd_nmi_n_d;
  logic [7:0] main_dout_q, main_dout_d;
  logic [7:0] snd_dout_q, snd_dout_d;
  acc_t       m_acc, s_acc;
  logic [7:0] cmd_data, reply_data;
  logic       cmd_pend, reply_pend;

  // Sound-side accesses are dropped entirely while the sound CPU is held in reset.
  always_comb begin
    m_acc.rd   = main_cs & ~main_cs_q & ~main_wr;
    m_acc.wr   = main_cs & ~main_cs_q & main_wr;
    m_acc.addr = main_addr;
    s_acc.rd   = snd_cs & ~snd_cs_q & ~snd_wr & ~snd_rst_q;
    s_acc.wr   = snd_cs & ~snd_cs_q & snd_wr & ~snd_rst_q;
    s_acc.addr = snd_addr;
  end

  jtbubl_sndcomm_latch u_cmd (
    .clk24  (clk24),
    .rst_n  (rst_n),
    .set_i  (m_acc.wr && m_acc.addr == ADDR_CMD),
    .clr_i  (s_acc.rd && s_acc.addr == ADDR_CMD),
    .din_i  (main_din),
    .data_o (cmd_data),
    .pend_o (cmd_pend)
  );

`ifdef JTBUBL_SNDREPLY_EN
  jtbubl_sndcomm_latch u_reply (
    .clk24  (clk24),
    .rst_n  (rst_n),
    .set_i  (s_acc.wr && s_acc.addr == ADDR_CMD),
    .clr_i  ((m_acc.rd && m_acc.addr == ADDR_CMD) || snd_rst_q),
    .din_i  (snd_din),
    .data_o (reply_data),
    .pend_o (reply_pend)
  );
`else
  logic unused_snd_din;
  assign unused_snd_din = ^snd_din;
  assign reply_data     = RST_LATCH;
  assign reply_pend     = 1'b0;
`endif

  always_comb begin
    snd_rst_d   = snd_rst_q;
    nmi_en_d    = nmi_en_q;
    main_dout_d = main_dout_q;
    snd_dout_d  = snd_dout_q;

    if (m_acc.wr && m_acc.addr == ADDR_RST) snd_rst_d = main_din[0];

    if (snd_rst_q) begin
      nmi_en_d = 1'b0;
    end else if (s_acc.wr) begin
      if (s_acc.addr == ADDR_NMI_ON)  nmi_en_d = 1'b1;
      if (s_acc.addr == ADDR_NMI_OFF) nmi_en_d = 1'b0;
    end

    if (m_acc.rd) begin
      case (m_acc.addr)
        ADDR_CMD:    main_dout_d = reply_data;
        ADDR_STATUS: main_dout_d = status_byte(reply_pend, cmd_pend);
        default:     main_dout_d = OPEN_BUS;
      endcase
    end

    if (s_acc.rd) begin
      case (s_acc.addr)
        ADDR_CMD:    snd_dout_d = cmd_data;
        ADDR_STATUS: snd_dout_d = status_byte(reply_pend, cmd_pend);
        default:     snd_dout_d = OPEN_BUS;
      endcase
    end

    snd_nmi_n_d = ~(cmd_pend & nmi_en_q & ~snd_rst_q);
  end

  // Strobe history resets to "high" so an access straddling reset release is ignored.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      main_cs_q   <= 1'b1;
      snd_cs_q    <= 1'b1;
      snd_rst_q   <= RST_SND_RST;
      nmi_en_q    <= 1'b0;
      snd_nmi_n_q <= 1'b1;
      main_dout_q <= RST_DOUT;
      snd_dout_q  <= RST_DOUT;
    end else begin
      main_cs_q   <= main_cs;
      snd_cs_q    <= snd_cs;
      snd_rst_q   <= snd_rst_d;
      nmi_en_q    <= nmi_en_d;
      snd_nmi_n_q <= snd_nmi_n_d;
      main_dout_q <= main_dout_d;
      snd_dout_q  <= snd_dout_d;
    end
  end

  assign main_dout = main_dout_q;
  assign snd_dout  = snd_dout_q;
  assign snd_nmi_n = snd_nmi_n_q;
  assign snd_rst   = snd_rst_q;

endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Scoreboard bench for jtbubl_sndcomm: directed scenarios followed by random accesses.
module tb_jtbubl_sndcomm;

  logic       clk24 = 1'b0;
  logic       rst_n = 1'b0;
  logic       main_cs = 1'b0, main_wr = 1'b0;
  logic [1:0] main_addr = 2'd0;
  logic [7:0] main_din = 8'h00;
  logic [7:0] main_dout;
  logic       snd_cs = 1'b0, snd_wr = 1'b0;
  logic [1:0] snd_addr = 2'd0;
  logic [7:0] snd_din = 8'h00;
  logic [7:0] snd_dout;
  logic       snd_nmi_n, snd_rst;

  jtbubl_sndcomm dut (
    .clk24(clk24), .rst_n(rst_n),
    .main_cs(main_cs), .main_wr(main_wr), .main_addr(main_addr),
    .main_din(main_din), .main_dout(main_dout),
    .snd_cs(snd_cs), .snd_wr(snd_wr), .snd_addr(snd_addr),
    .snd_din(snd_din), .snd_dout(snd_dout),
    .snd_nmi_n(snd_nmi_n), .snd_rst(snd_rst)
  );

  always #5 clk24 = ~clk24;

  int cyc = 0;
  always @(posedge clk24) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: mailbox contents as seen by software.
  logic [7:0] m_cmd, m_rep, m_mdout, m_sdout;
  bit         m_cp, m_rp, m_nmi, m_rst;

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] exp;
    string      nm;
  } sb_t;
  sb_t sb[$];

  task automatic push(input int kind, input logic [7:0] exp, input string nm);
    sb_t it;
    it.due = cyc + 1; it.kind = kind; it.exp = exp; it.nm = nm;
    sb.push_back(it);
  endtask

  always @(negedge clk24) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic [7:0] act;
        case (sb[i].kind)
          0:       act = main_dout;
          1:       act = snd_dout;
          2:       act = {7'b0, snd_nmi_n};
          default: act = {7'b0, snd_rst};
        endcase
        chk(sb[i].nm, act, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic model_reset();
    m_cmd = 8'h00; m_rep = 8'h00; m_cp = 0; m_rp = 0; m_nmi = 0; m_rst = 1;
    m_mdout = 8'hFF; m_sdout = 8'hFF;
  endtask

  // Accesses starting in the same cycle see the old state; clears apply before sets.
  task automatic model_start(input bit mg, input bit mw, input logic [1:0] ma, input logic [7:0] md,
                             input bit sg, input bit sw, input logic [1:0] sa, input logic [7:0] sd);
    logic [7:0] status;
    bit         s_act;
    s_act  = sg && !m_rst;
    status = {6'b0, m_rp, m_cp};
    if (mg && !mw) begin
      m_mdout = (ma == 0) ? m_rep : (ma == 1) ? status : 8'hFF;
      push(0, m_mdout, "main_read");
    end
    if (s_act && !sw) begin
      m_sdout = (sa == 0) ? m_cmd : (sa == 1) ? status : 8'hFF;
      push(1, m_sdout, "snd_read");
    end
    if (mg && !mw && ma == 0) m_rp = 0;
    if (s_act && !sw && sa == 0) m_cp = 0;
    if (mg && mw && ma == 0) begin m_cmd = md; m_cp = 1; end
    if (mg && mw && ma == 3) m_rst = md[0];
    if (s_act && sw) begin
`ifdef JTBUBL_SNDREPLY_EN
      if (sa == 0) begin m_rep = sd; m_rp = 1; end
`endif
      if (sa == 1) m_nmi = 1;
      if (sa == 2) m_nmi = 0;
    end
    if (m_rst) begin m_nmi = 0; m_rp = 0; end
  endtask

  task automatic acc(input bit mg, input bit mw, input logic [1:0] ma, input logic [7:0] md,
                     input int mdel, input int mhold,
                     input bit sg, input bit sw, input logic [1:0] sa, input logic [7:0] sd,
                     input int sdel, input int shold);
    int mend, send, tend;
    mend = mg ? mdel + mhold : 0;
    send = sg ? sdel + shold : 0;
    tend = ((mend > send) ? mend : send) + 3;
    for (int t = 0; t <= tend; t++) begin
      bit ms, ss;
      @(negedge clk24);
      ms = mg && (t == mdel);
      ss = sg && (t == sdel);
      if (ms || ss) model_start(ms, mw, ma, md, ss, sw, sa, sd);
      if (ms) begin main_cs = 1; main_wr = mw; main_addr = ma; main_din = md; end
      if (ss) begin snd_cs = 1; snd_wr = sw; snd_addr = sa; snd_din = sd; end
      if (mg && t == mend) main_cs = 0;
      if (sg && t == send) snd_cs = 0;
    end
    push(2, {7'b0, ~(m_cp & m_nmi & ~m_rst)}, "snd_nmi_n");
    push(3, {7'b0, m_rst}, "snd_rst");
    push(0, m_mdout, "main_dout_held");
    push(1, m_sdout, "snd_dout_held");
    @(negedge clk24);
  endtask

  task automatic mw_(input logic [1:0] a, input logic [7:0] d, input int hold = 1);
    acc(1, 1, a, d, 0, hold, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic mr_(input logic [1:0] a);
    acc(1, 0, a, 0, 0, 1, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic sw_(input logic [1:0] a, input logic [7:0] d);
    acc(0, 0, 0, 0, 0, 1, 1, 1, a, d, 0, 1);
  endtask
  task automatic sr_(input logic [1:0] a);
    acc(0, 0, 0, 0, 0, 1, 1, 0, a, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk24);
    chk("rst_main_dout", main_dout, 8'hFF);
    chk("rst_snd_dout", snd_dout, 8'hFF);
    chk("rst_nmi_n", {7'b0, snd_nmi_n}, 8'h01);
    chk("rst_snd_rst", {7'b0, snd_rst}, 8'h01);
    rst_n = 1'b1;

    // Sound CPU out of reset, NMI on, command delivery.
    mw_(3, 8'h00);
    sw_(1, 8'h00);
    mw_(0, 8'h5A);
    mr_(1);
    sr_(0);
    sw_(2, 8'h00);

    // Held strobe acts once; a mid-hold command read must not be undone by a repeat.
    mw_(0, 8'h11, 20);
    mr_(1);
    acc(1, 1, 0, 8'h11, 0, 20, 1, 0, 0, 0, 6, 1);
    mr_(1);

    // Write and read of the command latch in the same cycle.
    acc(1, 1, 0, 8'h22, 0, 1, 1, 0, 0, 0, 0, 1);
    mr_(1);
    sr_(0);

    // Reply path.
    sw_(0, 8'hC3);
    mr_(1);
    mr_(0);
    mr_(1);
    mr_(2);
    sr_(3);

    // NMI with pending command, overwrite while pending, then sound reset.
    sw_(1, 8'h00);
    mw_(0, 8'h33);
    mw_(0, 8'h44);
    mw_(3, 8'h01);
    sw_(1, 8'h00);
    sr_(1);
    mw_(0, 8'h55);
    mr_(1);

    // Asynchronous reset pulse in the middle of a held command write.
    @(negedge clk24);
    main_cs = 1; main_wr = 1; main_addr = 0; main_din = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_main_dout", main_dout, 8'hFF);
    chk("arst_snd_dout", snd_dout, 8'hFF);
    chk("arst_nmi_n", {7'b0, snd_nmi_n}, 8'h01);
    chk("arst_snd_rst", {7'b0, snd_rst}, 8'h01);
    model_reset();
    repeat (2) @(negedge clk24);
    rst_n = 1'b1;
    repeat (3) @(negedge clk24);
    main_cs = 1'b0;
    repeat (2) @(negedge clk24);
    mr_(1);
    mw_(3, 8'h00);
    sr_(0);

    for (int n = 0; n < 250; n++) begin
      bit         mg, mwr, sg, swr;
      logic [1:0] ma, sa;
      logic [7:0] md, sd;
      mg  = ($urandom_range(0, 3) != 0);
      sg  = ($urandom_range(0, 3) != 0);
      mwr = $urandom_range(0, 1);
      swr = $urandom_range(0, 1);
      ma  = 2'($urandom_range(0, 3));
      sa  = 2'($urandom_range(0, 3));
      md  = 8'($urandom);
      sd  = 8'($urandom);
      if (ma == 3 && $urandom_range(0, 3) != 0) md[0] = 1'b0;
      acc(mg, mwr, ma, md, $urandom_range(0, 3), $urandom_range(1, 4),
          sg, swr, sa, sd, $urandom_range(0, 3), $urandom_range(1, 4));
    end

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk24);
    while (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, expected %02h", sb[0].nm, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
